nochange_monitor: RTL
=====================

NOCHANGE_MONITOR -- requirements
Module: nochange_monitor

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the width of the monitored data bus.
REQ-002 The block SHALL have parameter START_OFF, default 0, meaning the number of clk cycles from the reference rising edge to the window opening (0..15).
REQ-003 The block SHALL have parameter END_OFF, default 0, meaning the number of clk cycles the window stays open after the reference falling edge (0..15).
REQ-004 The block SHALL have parameter CW, default 8, meaning the width of the violation counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single sampling clock; all logic is rising-edge clk.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port ref_sig, input, 1 bit: the reference signal whose high phase defines the no-change window.
REQ-008 The block SHALL have port data, input, DW bits: the monitored bus.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear of viol_cnt.
REQ-010 The block SHALL have port viol, output, 1 bit: a one-cycle violation pulse.
REQ-011 The block SHALL have port in_window, output, 1 bit: high while the FSM is in ACTIVE or DLY_E.
REQ-012 The block SHALL have port viol_cnt, output, CW bits: the saturating violation count.

Function
REQ-013 The block SHALL register ref_sig/data into stage s1 and s1 into stage s2 each clk; rise = s1.ref & ~s2.ref; fall = ~s1.ref & s2.ref; chg = (s1.data != s2.data).
REQ-014 The FSM SHALL have states IDLE, DLY_S, ACTIVE and DLY_E, with a 4-bit down-counter dcnt.
REQ-015 In IDLE, on rise the FSM SHALL go to ACTIVE if START_OFF=0, else to DLY_S with dcnt=START_OFF; chg in the same sample as rise SHALL NOT be a violation.
REQ-016 In DLY_S, dcnt SHALL decrement; at dcnt=1 the FSM SHALL go to ACTIVE; a fall SHALL return it to IDLE with no violation (empty window); chg is ignored.
REQ-017 In ACTIVE, chg without fall SHALL be a violation; on fall the FSM SHALL go to IDLE if END_OFF=0, else to DLY_E with dcnt=END_OFF.
REQ-018 In ACTIVE, chg coincident with fall SHALL be a violation only when END_OFF>0.
REQ-019 In DLY_E, chg SHALL be a violation; dcnt SHALL decrement and reach IDLE at dcnt=1; a rise in DLY_E SHALL be handled exactly as a rise in IDLE, and same-sample chg SHALL be a violation (the old window still owns it).
REQ-020 viol SHALL be registered, high for exactly one cycle per violating sample, with latency 2 clk edges from the data change at the input pins to viol high.
REQ-021 Consecutive violating samples SHALL produce viol high on consecutive cycles, one count each.
REQ-022 viol_cnt SHALL increment by 1 per viol, saturate at 2^CW-1, and clear to 0 on clr; clr coincident with viol SHALL yield 0 (clr wins).
REQ-023 in_window SHALL be a registered decode of the FSM state, with no combinational input-to-output paths.

Reset
REQ-024 On rst, the s1/s2 registers SHALL clear to 0, the FSM SHALL go to IDLE, and dcnt, viol, in_window and viol_cnt SHALL go to 0, in the same edge.
REQ-025 rst mid-window SHALL abandon the window with no violation reported.
REQ-026 ref_sig high at reset release SHALL be detected as a rise 2 edges later.

Configuration
REQ-027 With NOCHANGE_MON_COUNT_EN defined, the viol_cnt counter and clr SHALL function per REQ-022.
REQ-028 Without NOCHANGE_MON_COUNT_EN, viol_cnt SHALL be constant 0, clr SHALL be ignored, and no counter flops SHALL be synthesised; viol and in_window SHALL be unaffected.

Verification
REQ-029 The bench SHALL cover: defaults; ref_sig high cycles 10-19; data 0x00->0x5A at cycle 14 -> one viol pulse at cycle 16, viol_cnt=1.
REQ-030 The bench SHALL cover: defaults; data changes in the same cycle as ref_sig rises and in the same cycle as it falls -> no viol, viol_cnt=0.
REQ-031 The bench SHALL cover: START_OFF=3, END_OFF=2; ref_sig high for 2 cycles with data toggling each cycle -> no viol; then high for 8 cycles with a change 1 cycle after the fall -> exactly 1 viol.
REQ-032 The bench SHALL cover: CW=2; 5 violating changes in one window -> viol_cnt reads 1,2,3,3,3; clr coincident with the 5th viol -> 0.
REQ-033 The bench SHALL cover: rst asserted for 1 cycle mid-window with data changing during reset -> no viol, in_window=0, viol_cnt=0 after reset.
REQ-034 The bench SHALL cover: a build without NOCHANGE_MON_COUNT_EN running the REQ-029 stimulus -> viol pulses identically and viol_cnt stays 0.

Source files
------------

// File: rtl/nochange_monitor.sv
// Purpose: flags data bus changes inside the window opened by the reference signal's high phase (optionally offset).
// Latency: viol rises 2 clk edges after the offending data change at the pins; in_window follows the FSM state registers.
// Backpressure: none; pure monitor. Optional saturating count of violations when NOCHANGE_MON_COUNT_EN is defined.
module nochange_monitor #(
    parameter int DW        = 8,
    parameter int START_OFF = 0,
    parameter int END_OFF   = 0,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ref_sig,
    input  logic [DW-1:0] data,
    input  logic          clr,
    output logic          viol,
    output logic          in_window,
    output logic [CW-1:0] viol_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DLY_S  = 2'd1,
        ACTIVE = 2'd2,
        DLY_E  = 2'd3
    } state_t;

    // One sample of the monitored pins
    typedef struct packed {
        logic          ref_v;
        logic [DW-1:0] dat;
    } smp_t;

    localparam logic [3:0] START_D  = 4'(START_OFF);
    localparam logic [3:0] END_D    = 4'(END_OFF);
    localparam bit         HAS_END  = (END_OFF != 0);
    // Where a rising reference edge sends the FSM; dcnt is loaded with START_D either way
    localparam state_t     START_ST = (START_OFF == 0) ? ACTIVE : DLY_S;

    smp_t       s1;
    smp_t       s2;
    state_t     state;
    state_t     state_n;
    logic [3:0] dcnt;
    logic [3:0] dcnt_n;
    logic       viol_n;
    logic       rise;
    logic       fall;
    logic       chg;

    assign rise = s1.ref_v & ~s2.ref_v;
    assign fall = ~s1.ref_v & s2.ref_v;
    assign chg  = (s1.dat != s2.dat);

    // Window FSM: next state, delay counter and violation decision for the current sample
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        viol_n  = 1'b0;
        case (state)
            IDLE: begin
                // A change landing with the rise belongs to no window yet
                if (rise) begin
                    state_n = START_ST;
                    dcnt_n  = START_D;
                end
            end
            DLY_S: begin
                // Changes before the window opens are ignored
                if (fall) begin
                    state_n = IDLE;
                    dcnt_n  = 4'd0;
                end else if (dcnt <= 4'd1) begin
                    state_n = ACTIVE;
                    dcnt_n  = 4'd0;
                end else begin
                    dcnt_n  = dcnt - 4'd1;
                end
            end
            ACTIVE: begin
                if (fall) begin
                    // With no trailing extension the falling sample closes the window
                    viol_n = chg & HAS_END;
                    if (HAS_END) begin
                        state_n = DLY_E;
                        dcnt_n  = END_D;
                    end else begin
                        state_n = IDLE;
                        dcnt_n  = 4'd0;
                    end
                end else begin
                    viol_n = chg;
                end
            end
            DLY_E: begin
                // The trailing window still owns a change that coincides with a new rise
                viol_n = chg;
                if (rise) begin
                    state_n = START_ST;
                    dcnt_n  = START_D;
                end else if (dcnt <= 4'd1) begin
                    state_n = IDLE;
                    dcnt_n  = 4'd0;
                end else begin
                    dcnt_n  = dcnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                dcnt_n  = 4'd0;
            end
        endcase
    end

    // Input sample pipeline, FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            state     <= IDLE;
            dcnt      <= 4'd0;
            viol      <= 1'b0;
            in_window <= 1'b0;
        end else begin
            s1        <= '{ref_v: ref_sig, dat: data};
            s2        <= s1;
            state     <= state_n;
            dcnt      <= dcnt_n;
            viol      <= viol_n;
            in_window <= (state_n == ACTIVE) || (state_n == DLY_E);
        end
    end

`ifdef NOCHANGE_MON_COUNT_EN
    logic [CW-1:0] cnt;

    // Saturating violation count, updated on the same edge that raises viol; clr wins
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (viol_n && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign viol_cnt = cnt;
`else
    logic unused_clr;

    // Counter not built: the count reads zero and clr has no effect
    assign unused_clr = clr;
    assign viol_cnt   = '0;
`endif

endmodule
